// File: rtl/instr_fetch_ras.sv
// Instruction fetch unit: PC sequencing with page-relative branch/jump, CALL/RET through an
// internal return-address stack, pipeline stall and a terminal HALT state.
module instr_fetch_ras #(
    parameter int                ADDR_W    = 16,
    parameter int                DST_W     = 8,
    parameter int                RAS_DEPTH = 4,
    parameter logic [ADDR_W-1:0] RESET_PC  = '0
) (
    input  logic                          CLK,
    input  logic                          reset_ctrl_n,
    input  logic [DST_W-1:0]              dst_in,
    input  logic                          br_ctrl,
    input  logic                          zero_ctrl,
    input  logic                          jmp_ctrl,
    input  logic                          call_ctrl,
    input  logic                          ret_ctrl,
    input  logic                          halt_ctrl,
    input  logic                          stall_ctrl,
    output logic [ADDR_W-1:0]             instr_addr,
    output logic [$clog2(RAS_DEPTH):0]    ras_depth,
    output logic                          ras_ovf,
    output logic                          ras_unf,
    output logic                          halted
);

    localparam int PTR_W   = $clog2(RAS_DEPTH);
    localparam int DEPTH_W = PTR_W + 1;

    typedef enum logic {
        RUN,
        HALT
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] ras_mem [RAS_DEPTH];

    logic [ADDR_W-1:0] pc_inc;
    logic [ADDR_W-1:0] target;
    logic [ADDR_W-1:0] ras_top;
    logic [PTR_W-1:0]  top_idx;
    logic              ras_full;
    logic              ras_empty;

    // Target keeps the page of the incremented PC, so a branch on the last word of a page lands in the next page.
    always_comb begin
        pc_inc    = instr_addr + ADDR_W'(1);
        target    = {pc_inc[ADDR_W-1:DST_W], dst_in};
        top_idx   = PTR_W'(ras_depth - DEPTH_W'(1));
        ras_top   = ras_mem[top_idx];
        ras_full  = (ras_depth == DEPTH_W'(RAS_DEPTH));
        ras_empty = (ras_depth == '0);
    end

    always_ff @(posedge CLK or negedge reset_ctrl_n) begin
        if (!reset_ctrl_n) begin
            state      <= RUN;
            instr_addr <= RESET_PC;
            ras_depth  <= '0;
            ras_ovf    <= 1'b0;
            ras_unf    <= 1'b0;
            halted     <= 1'b0;
            for (int i = 0; i < RAS_DEPTH; i++) begin
                ras_mem[i] <= '0;
            end
        end else begin
            case (state)
                RUN: begin
                    if (!stall_ctrl) begin
                        if (halt_ctrl) begin
                            state  <= HALT;
                            halted <= 1'b1;
                        end else if (ret_ctrl) begin
                            if (!ras_empty) begin
                                instr_addr <= ras_top;
                                ras_depth  <= ras_depth - DEPTH_W'(1);
                            end else begin
                                instr_addr <= pc_inc;
                                ras_unf    <= 1'b1;
                            end
                        end else if (call_ctrl) begin
                            instr_addr <= target;
                            if (!ras_full) begin
                                ras_mem[ras_depth[PTR_W-1:0]] <= pc_inc;
                                ras_depth                     <= ras_depth + DEPTH_W'(1);
                            end else begin
                                ras_ovf <= 1'b1;
                            end
                        end else if (jmp_ctrl || (br_ctrl && zero_ctrl)) begin
                            instr_addr <= target;
                        end else begin
                            instr_addr <= pc_inc;
                        end
                    end
                end
                // Only reset leaves HALT; every control input is ignored here.
                HALT: begin
                    state  <= HALT;
                    halted <= 1'b1;
                end
                default: begin
                    state <= HALT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instr_fetch_ras.sv
// Self-checking bench for instr_fetch_ras: vector table, directed corner sequences and a
// randomized run against a queue-based reference model.
module tb_instr_fetch_ras;

    logic        CLK;
    logic        reset_ctrl_n;
    logic [7:0]  dst_in;
    logic        br_ctrl, zero_ctrl, jmp_ctrl, call_ctrl, ret_ctrl, halt_ctrl, stall_ctrl;
    logic [15:0] instr_addr;
    logic [2:0]  ras_depth;
    logic        ras_ovf, ras_unf, halted;

    logic [15:0] w_addr;
    logic [2:0]  w_depth;
    logic        w_ovf, w_unf, w_halted;

    int assert_count = 0;
    int fail_count   = 0;

    // ctl bit order: stall, halt, ret, call, jmp, br, zero
    typedef struct {
        logic [6:0]  ctl;
        logic [7:0]  dst;
        logic [15:0] pc;
        logic [2:0]  depth;
        logic        ovf;
        logic        unf;
        logic        hlt;
    } vec_t;

    vec_t vecs[14];

    // Reference model state
    logic [15:0] m_pc;
    logic [15:0] m_stack[$];
    logic        m_ovf, m_unf, m_halted;

    instr_fetch_ras dut (
        .CLK(CLK), .reset_ctrl_n(reset_ctrl_n), .dst_in(dst_in),
        .br_ctrl(br_ctrl), .zero_ctrl(zero_ctrl), .jmp_ctrl(jmp_ctrl),
        .call_ctrl(call_ctrl), .ret_ctrl(ret_ctrl), .halt_ctrl(halt_ctrl),
        .stall_ctrl(stall_ctrl), .instr_addr(instr_addr), .ras_depth(ras_depth),
        .ras_ovf(ras_ovf), .ras_unf(ras_unf), .halted(halted)
    );

    instr_fetch_ras #(.RESET_PC(16'hFFFE)) dut_wrap (
        .CLK(CLK), .reset_ctrl_n(reset_ctrl_n), .dst_in(dst_in),
        .br_ctrl(br_ctrl), .zero_ctrl(zero_ctrl), .jmp_ctrl(jmp_ctrl),
        .call_ctrl(call_ctrl), .ret_ctrl(ret_ctrl), .halt_ctrl(halt_ctrl),
        .stall_ctrl(stall_ctrl), .instr_addr(w_addr), .ras_depth(w_depth),
        .ras_ovf(w_ovf), .ras_unf(w_unf), .halted(w_halted)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    function automatic vec_t mkVec(input logic [6:0] ctl, input logic [7:0] dst,
                                   input logic [15:0] pc, input logic [2:0] depth,
                                   input logic ovf, input logic unf, input logic hlt);
        vec_t v;
        v.ctl = ctl; v.dst = dst; v.pc = pc; v.depth = depth;
        v.ovf = ovf; v.unf = unf; v.hlt = hlt;
        return v;
    endfunction

    task automatic applyStimulus(input logic [6:0] ctl, input logic [7:0] dst);
        {stall_ctrl, halt_ctrl, ret_ctrl, call_ctrl, jmp_ctrl, br_ctrl, zero_ctrl} = ctl;
        dst_in = dst;
    endtask

    task automatic checkOutput(input string name, input logic [15:0] pc, input logic [2:0] depth,
                               input logic ovf, input logic unf, input logic hlt);
        assert_count++;
        if (instr_addr !== pc || ras_depth !== depth || ras_ovf !== ovf ||
            ras_unf !== unf || halted !== hlt) begin
            fail_count++;
            $display("[TB] FAIL %s: got pc=%h depth=%0d ovf=%b unf=%b halted=%b, expected pc=%h depth=%0d ovf=%b unf=%b halted=%b",
                     name, instr_addr, ras_depth, ras_ovf, ras_unf, halted, pc, depth, ovf, unf, hlt);
        end
    endtask

    task automatic checkWrap(input string name, input logic [15:0] pc);
        assert_count++;
        if (w_addr !== pc) begin
            fail_count++;
            $display("[TB] FAIL %s: got pc=%h, expected pc=%h", name, w_addr, pc);
        end
    endtask

    // One clocked cycle: drive, take the edge, sample 1 time unit later.
    task automatic step(input logic [6:0] ctl, input logic [7:0] dst);
        applyStimulus(ctl, dst);
        @(posedge CLK);
        #1;
    endtask

    task automatic modelReset();
        m_pc = 16'h0000;
        m_stack.delete();
        m_ovf = 1'b0;
        m_unf = 1'b0;
        m_halted = 1'b0;
    endtask

    task automatic doReset(input string name);
        applyStimulus(7'b0, 8'h00);
        reset_ctrl_n = 1'b0;
        #2;
        checkOutput(name, 16'h0000, 3'd0, 1'b0, 1'b0, 1'b0);
        @(posedge CLK);
        #1;
        reset_ctrl_n = 1'b1;
        modelReset();
    endtask

    task automatic modelStep(input logic [6:0] ctl, input logic [7:0] dst);
        logic        s, h, r, c, j, b, z;
        logic [15:0] inc, tgt;
        {s, h, r, c, j, b, z} = ctl;
        inc = 16'((32'(m_pc) + 1) % 65536);
        tgt = {inc[15:8], dst};
        if (!m_halted && !s) begin
            if (h) m_halted = 1'b1;
            else if (r) begin
                if (m_stack.size() > 0) m_pc = m_stack.pop_back();
                else begin m_pc = inc; m_unf = 1'b1; end
            end else if (c) begin
                m_pc = tgt;
                if (m_stack.size() < 4) m_stack.push_back(inc);
                else m_ovf = 1'b1;
            end else if (j || (b && z)) m_pc = tgt;
            else m_pc = inc;
        end
    endtask

    initial begin
        logic [6:0] rc;
        logic [7:0] rd;
        int         halt_cycles;

        vecs[0]  = mkVec(7'b0000000, 8'h00, 16'h0001, 3'd0, 0, 0, 0);
        vecs[1]  = mkVec(7'b0000000, 8'h00, 16'h0002, 3'd0, 0, 0, 0);
        vecs[2]  = mkVec(7'b0000100, 8'h40, 16'h0040, 3'd0, 0, 0, 0);
        vecs[3]  = mkVec(7'b0001000, 8'h80, 16'h0080, 3'd1, 0, 0, 0);
        vecs[4]  = mkVec(7'b0010000, 8'h00, 16'h0041, 3'd0, 0, 0, 0);
        vecs[5]  = mkVec(7'b0000010, 8'h10, 16'h0042, 3'd0, 0, 0, 0);
        vecs[6]  = mkVec(7'b0000011, 8'h10, 16'h0010, 3'd0, 0, 0, 0);
        vecs[7]  = mkVec(7'b1001000, 8'h99, 16'h0010, 3'd0, 0, 0, 0);
        vecs[8]  = mkVec(7'b0001000, 8'h20, 16'h0020, 3'd1, 0, 0, 0);
        vecs[9]  = mkVec(7'b0011000, 8'h55, 16'h0011, 3'd0, 0, 0, 0);
        vecs[10] = mkVec(7'b0010000, 8'h00, 16'h0012, 3'd0, 0, 1, 0);
        vecs[11] = mkVec(7'b0000111, 8'h30, 16'h0030, 3'd0, 0, 1, 0);
        vecs[12] = mkVec(7'b0100100, 8'h60, 16'h0030, 3'd0, 0, 1, 1);
        vecs[13] = mkVec(7'b0001000, 8'h77, 16'h0030, 3'd0, 0, 1, 1);

        reset_ctrl_n = 1'b1;
        applyStimulus(7'b0, 8'h00);
        #3;

        $display("[TB] reset and sequential fetch");
        doReset("reset_state");
        for (int i = 1; i <= 5; i++) begin
            step(7'b0, 8'h00);
            checkOutput($sformatf("seq_%0d", i), 16'(i), 3'd0, 0, 0, 0);
        end
        #2;
        reset_ctrl_n = 1'b0;
        #1;
        checkOutput("async_reset_midrun", 16'h0000, 3'd0, 0, 0, 0);

        $display("[TB] vector table");
        doReset("reset_table");
        for (int i = 0; i < 14; i++) begin
            step(vecs[i].ctl, vecs[i].dst);
            checkOutput($sformatf("vec_%0d", i), vecs[i].pc, vecs[i].depth,
                        vecs[i].ovf, vecs[i].unf, vecs[i].hlt);
        end

        $display("[TB] page-crossing branch");
        doReset("reset_page");
        for (int i = 0; i < 510; i++) step(7'b0, 8'h00);
        checkOutput("reach_01fe", 16'h01FE, 3'd0, 0, 0, 0);
        step(7'b0000010, 8'h10);
        checkOutput("br_not_taken", 16'h01FF, 3'd0, 0, 0, 0);
        step(7'b0000011, 8'h10);
        checkOutput("br_taken_next_page", 16'h0210, 3'd0, 0, 0, 0);
        step(7'b0001000, 8'h05);
        checkOutput("call_from_page2", 16'h0205, 3'd1, 0, 0, 0);
        step(7'b0010000, 8'h00);
        checkOutput("ret_to_page2", 16'h0211, 3'd0, 0, 0, 0);

        $display("[TB] RAS overflow and underflow");
        doReset("reset_ras");
        for (int i = 1; i <= 5; i++) begin
            step(7'b0001000, 8'(i * 16));
            checkOutput($sformatf("call_%0d", i), 16'(i * 16), 3'(i > 4 ? 4 : i), i > 4, 0, 0);
        end
        for (int i = 1; i <= 4; i++) begin
            step(7'b0010000, 8'h00);
            checkOutput($sformatf("ret_%0d", i), 16'((5 - i) * 16 - 15), 3'(4 - i), 1, 0, 0);
        end
        step(7'b0010000, 8'h00);
        checkOutput("ret_empty", 16'h0002, 3'd0, 1, 1, 0);

        $display("[TB] stall behaviour");
        doReset("reset_stall");
        step(7'b0001000, 8'h20);
        checkOutput("call_before_stall", 16'h0020, 3'd1, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            step(7'b1001000, 8'hAA);
            checkOutput($sformatf("stall_call_%0d", i), 16'h0020, 3'd1, 0, 0, 0);
        end
        step(7'b1100000, 8'h00);
        checkOutput("stall_blocks_halt", 16'h0020, 3'd1, 0, 0, 0);
        step(7'b0000000, 8'h00);
        checkOutput("after_stall", 16'h0021, 3'd1, 0, 0, 0);

        $display("[TB] PC wrap");
        doReset("reset_wrap");
        checkWrap("wrap_reset_pc", 16'hFFFE);
        step(7'b0, 8'h00);
        checkWrap("wrap_ffff", 16'hFFFF);
        step(7'b0, 8'h00);
        checkWrap("wrap_zero", 16'h0000);

        $display("[TB] randomized run against model");
        doReset("reset_random");
        halt_cycles = 0;
        for (int i = 0; i < 2000; i++) begin
            rc[6] = ($urandom_range(0, 99) < 12);
            rc[5] = ($urandom_range(0, 99) < 2);
            rc[4] = ($urandom_range(0, 99) < 25);
            rc[3] = ($urandom_range(0, 99) < 30);
            rc[2] = ($urandom_range(0, 99) < 15);
            rc[1] = ($urandom_range(0, 99) < 30);
            rc[0] = ($urandom_range(0, 99) < 50);
            rd    = 8'($urandom);
            applyStimulus(rc, rd);
            @(posedge CLK);
            modelStep(rc, rd);
            #1;
            checkOutput($sformatf("rand_%0d", i), m_pc, 3'(m_stack.size()), m_ovf, m_unf, m_halted);
            if (m_halted) halt_cycles++;
            if (halt_cycles > 4 || $urandom_range(0, 199) == 0) begin
                halt_cycles = 0;
                doReset("reset_in_random");
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
        $finish;
    end

endmodule
